jtkiwi_romrd: RTL and testbench
===============================

Name: jtkiwi_romrd

Overview:
- Responder side of the CPU ROM fetch interface (rom_addr/rom_cs -> rom_ok/rom_data) used by the Kiwi main and sub CPUs.
- Serves byte reads from a one-line, 16-bit cache.
- On a miss, issues a word request to the SDRAM controller, fills the line and returns the selected byte.
- One instance per CPU ROM slot, between the CPU module and the SDRAM bank arbiter.

Parameters:
AW, 15, CPU byte address width; SDRAM word address width is AW-1
LE, 1, byte order: 1 = addr[0]==0 selects data[7:0]; 0 = addr[0]==0 selects data[15:8]

Ports:
clk  in  1  system clock, 24 MHz domain
rst  in  1  synchronous reset, active-high
flush  in  1  invalidate cache (asserted during ROM download)
rom_cs  in  1  CPU read request
rom_addr  in  AW  CPU byte address
rom_ok  out  1  rom_data valid for the current rom_addr
rom_data  out  8  byte read
sdram_req  out  1  word request to SDRAM controller
sdram_addr  out  AW-1  word address
sdram_ack  in  1  controller accepted the request (1-cycle strobe)
sdram_dst  in  1  sdram_data valid (1-cycle strobe)
sdram_data  in  16  fetched word

Behaviour:
- Reset (rst sampled high on a clk edge):
  - state=IDLE, sdram_req=0, sdram_addr=0, valid=0, tag=0, line=0.
  - rom_data=0, ok_r=0, addr_l=0, discard=0.
  - All outputs are low one edge after rst goes high.
- Hit: valid && tag==rom_addr[AW-1:1].
- rom_ok = ok_r && rom_cs && (rom_addr==addr_l); combinational qualification only, all state is registered.
  - rom_ok never goes high for an address other than the one whose byte is in rom_data.
- States:
  - IDLE:
    - If rom_cs && hit: on the next edge ok_r=1, addr_l=rom_addr, rom_data=byte of line selected by rom_addr[0] (per LE). Hit latency is 1 cycle.
    - If rom_cs && !hit && !flush: ok_r=0, sdram_req=1, sdram_addr=rom_addr[AW-1:1], next state REQ.
    - If !rom_cs: ok_r=0.
  - REQ:
    - sdram_req and sdram_addr are held stable until sdram_ack.
    - On sdram_ack, sdram_req=0 and next state WAIT.
    - If sdram_ack and sdram_dst arrive in the same cycle, the data is captured immediately and the next state is IDLE.
  - WAIT:
    - On sdram_dst: line=sdram_data, tag=sdram_addr, valid=!discard, discard=0, next state IDLE.
    - The hit is re-evaluated in IDLE, so a miss costs ack+dst latency plus 2 cycles before rom_ok.
- Outstanding fetches are never aborted:
  - A rom_addr change, or rom_cs dropping, during REQ/WAIT lets the fetch complete and fill the line.
  - IDLE then re-evaluates against the current address, which may miss again.
- ok_r is forced to 0 in every cycle spent in REQ/WAIT.
- flush:
  - Clears valid and ok_r on the next edge in any state.
  - If asserted in REQ/WAIT, sets discard, so the in-flight word is stored but valid stays 0.
  - While flush is high, no new request is started.
  - flush and sdram_dst in the same cycle: valid=0.
- Word address wrap: rom_addr all-ones maps to sdram_addr all-ones; no carry or overflow logic.
- rom_data holds its last value when rom_cs is low; rom_ok gates its use.
- No timeout: an unanswered request holds sdram_req indefinitely.
- rst asserted mid-fetch: returns to IDLE and drops sdram_req. The controller must tolerate a dropped request; a late dst is ignored in IDLE.

Test Plan:
- Cold miss:
  - Stimulus: after reset, rom_cs=1, rom_addr=0x0123; ack 3 cycles after req, dst 4 cycles after ack with data 0xBEEF.
  - Response: sdram_addr=0x0091; rom_ok rises 2 cycles after dst with rom_data=0xBE (LE=1, odd byte).
- Hit:
  - Stimulus: next access rom_addr=0x0122 with no new sdram_req.
  - Response: rom_ok=1 one cycle later, rom_data=0xEF.
- Address change mid-fetch:
  - Stimulus: miss on 0x0200, rom_addr switched to 0x0300 while in WAIT; dst=0x1122.
  - Response: line tagged 0x100, a second req with sdram_addr=0x180, rom_ok never high while rom_addr=0x0300 and data is stale.
- Same-cycle ack+dst:
  - Stimulus: miss on 0x0010, ack and dst together with 0x5A5A.
  - Response: state goes REQ->IDLE, rom_ok after 2 cycles, rom_data=0x5A.
- Flush during fetch:
  - Stimulus: miss on 0x0040, flush pulsed in WAIT, then dst.
  - Response: valid=0 and a new request for 0x0020 is issued once flush is low.
  - Then: flush while idle with a valid line forces a re-fetch.
- Reset mid-REQ:
  - Stimulus: rst high while sdram_req=1.
  - Response: sdram_req=0 and rom_ok=0 on the next edge; a late dst is ignored and valid stays 0.

Source files
------------

// File: rtl/jtkiwi_romrd.sv
// CPU ROM byte reader backed by a single 16-bit line cache.
// A miss fetches one word from the SDRAM controller, fills the line and then serves the byte.
//
// state | meaning
// IDLE  | serve hits from the line, start a fetch on a miss
// REQ   | sdram_req held high until the controller acknowledges
// WAIT  | request accepted, waiting for the data strobe
module jtkiwi_romrd #(
  parameter int AW = 15,
  parameter int LE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic          rom_ok,
  output logic [7:0]    rom_data,
  output logic          sdram_req,
  output logic [AW-2:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          sdram_dst,
  input  logic [15:0]   sdram_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        r_state,   w_state_nx;
  logic          r_valid,   w_valid_nx;
  logic [AW-2:0] r_tag,     w_tag_nx;
  logic [15:0]   r_line,    w_line_nx;
  logic [7:0]    r_data,    w_data_nx;
  logic          r_ok,      w_ok_nx;
  logic [AW-1:0] r_addr_l,  w_addr_l_nx;
  logic          r_discard, w_discard_nx;
  logic          r_req,     w_req_nx;
  logic [AW-2:0] r_saddr,   w_saddr_nx;

  logic          w_hit;
  logic          w_sel_hi;
  logic [7:0]    w_byte;

  assign w_hit    = r_valid && (r_tag == rom_addr[AW-1:1]);
  assign w_sel_hi = (LE != 0) ? rom_addr[0] : ~rom_addr[0];
  assign w_byte   = w_sel_hi ? r_line[15:8] : r_line[7:0];

  always_comb begin
    w_state_nx   = r_state;
    w_valid_nx   = r_valid;
    w_tag_nx     = r_tag;
    w_line_nx    = r_line;
    w_data_nx    = r_data;
    w_ok_nx      = 1'b0;
    w_addr_l_nx  = r_addr_l;
    w_discard_nx = r_discard;
    w_req_nx     = r_req;
    w_saddr_nx   = r_saddr;

    unique case (r_state)
      IDLE: begin
        if (rom_cs && w_hit) begin
          w_ok_nx     = 1'b1;
          w_addr_l_nx = rom_addr;
          w_data_nx   = w_byte;
        end else if (rom_cs && !flush) begin
          w_req_nx   = 1'b1;
          w_saddr_nx = rom_addr[AW-1:1];
          w_state_nx = REQ;
        end
      end
      REQ: begin
        if (flush) w_discard_nx = 1'b1;
        if (sdram_ack) begin
          w_req_nx = 1'b0;
          if (sdram_dst) begin
            w_line_nx    = sdram_data;
            w_tag_nx     = r_saddr;
            w_valid_nx   = !(r_discard || flush);
            w_discard_nx = 1'b0;
            w_state_nx   = IDLE;
          end else begin
            w_state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush) w_discard_nx = 1'b1;
        if (sdram_dst) begin
          w_line_nx    = sdram_data;
          w_tag_nx     = r_saddr;
          w_valid_nx   = !(r_discard || flush);
          w_discard_nx = 1'b0;
          w_state_nx   = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase

    // flush wins over a same-cycle hit or fill
    if (flush) begin
      w_valid_nx = 1'b0;
      w_ok_nx    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_tag     <= '0;
      r_line    <= '0;
      r_data    <= '0;
      r_ok      <= 1'b0;
      r_addr_l  <= '0;
      r_discard <= 1'b0;
      r_req     <= 1'b0;
      r_saddr   <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_valid   <= w_valid_nx;
      r_tag     <= w_tag_nx;
      r_line    <= w_line_nx;
      r_data    <= w_data_nx;
      r_ok      <= w_ok_nx;
      r_addr_l  <= w_addr_l_nx;
      r_discard <= w_discard_nx;
      r_req     <= w_req_nx;
      r_saddr   <= w_saddr_nx;
    end
  end

  assign rom_ok     = r_ok && rom_cs && (rom_addr == r_addr_l);
  assign rom_data   = r_data;
  assign sdram_req  = r_req;
  assign sdram_addr = r_saddr;

endmodule

// File: tb/tb_jtkiwi_romrd.sv
// Bench for jtkiwi_romrd: vector table, hand-written fetch corner cases, then random
// accesses checked against a transaction-level cache model.
module tb_jtkiwi_romrd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        rom_cs = 1'b0;
  logic [14:0] rom_addr = '0;
  logic        rom_ok;
  logic [7:0]  rom_data;
  logic        sdram_req;
  logic [13:0] sdram_addr;
  logic        sdram_ack = 1'b0;
  logic        sdram_dst = 1'b0;
  logic [15:0] sdram_data = '0;

  int checks = 0;
  int failures = 0;

  jtkiwi_romrd #(.AW(15), .LE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_ok     (rom_ok),
    .rom_data   (rom_data),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_dst  (sdram_dst),
    .sdram_data (sdram_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [14:0] addr;
    bit          hit;
    int          ackd;
    int          dstd;
    logic [15:0] data;
    logic [7:0]  expb;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem(input logic [13:0] w);
    return {w[7:0] ^ 8'h5C, w[13:6] ^ 8'hA3};
  endfunction

  // Request is visible; answer it, then expect the byte two edges after dst.
  task automatic serve(input int ackd, input int dstd, input logic [15:0] d,
                       input logic [7:0] expb, input logic [13:0] w);
    repeat (ackd) begin
      tick();
      chk("req_hold", 32'(sdram_req), 32'(1));
      chk("addr_hold", 32'(sdram_addr), 32'(w));
      chk("ok_in_req", 32'(rom_ok), 32'(0));
    end
    sdram_ack = 1'b1;
    if (dstd == 0) begin
      sdram_dst = 1'b1;
      sdram_data = d;
    end
    tick();
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    chk("req_drop", 32'(sdram_req), 32'(0));
    if (dstd > 0) begin
      repeat (dstd - 1) begin
        tick();
        chk("ok_in_wait", 32'(rom_ok), 32'(0));
      end
      sdram_dst = 1'b1;
      sdram_data = d;
      tick();
      sdram_dst = 1'b0;
    end
    chk("ok_after_fill", 32'(rom_ok), 32'(0));
    tick();
    chk("ok_miss", 32'(rom_ok), 32'(1));
    chk("data_miss", 32'(rom_data), 32'(expb));
    chk("req_idle", 32'(sdram_req), 32'(0));
  endtask

  task automatic access(input logic [14:0] a, input bit exp_hit, input int ackd,
                        input int dstd, input logic [15:0] d, input logic [7:0] expb);
    rom_cs = 1'b0;
    tick();
    rom_cs = 1'b1;
    rom_addr = a;
    #1;
    chk("ok_pre", 32'(rom_ok), 32'(0));
    tick();
    if (exp_hit) begin
      chk("hit_no_req", 32'(sdram_req), 32'(0));
      chk("ok_hit", 32'(rom_ok), 32'(1));
      chk("data_hit", 32'(rom_data), 32'(expb));
    end else begin
      chk("miss_req", 32'(sdram_req), 32'(1));
      chk("miss_addr", 32'(sdram_addr), 32'(a[14:1]));
      chk("ok_miss_start", 32'(rom_ok), 32'(0));
      serve(ackd, dstd, d, expb, a[14:1]);
    end
  endtask

  logic        m_valid;
  logic [13:0] m_tag;

  initial begin
    vecs[0] = '{15'h0123, 1'b0, 3, 4, 16'hBEEF, 8'hBE};
    vecs[1] = '{15'h0122, 1'b1, 0, 0, 16'h0000, 8'hEF};
    vecs[2] = '{15'h0123, 1'b1, 0, 0, 16'h0000, 8'hBE};
    vecs[3] = '{15'h0010, 1'b0, 0, 0, 16'h5A5A, 8'h5A};
    vecs[4] = '{15'h0011, 1'b1, 0, 0, 16'h0000, 8'h5A};
    vecs[5] = '{15'h7FFF, 1'b0, 1, 2, 16'h1234, 8'h12};
    vecs[6] = '{15'h7FFE, 1'b1, 0, 0, 16'h0000, 8'h34};
    vecs[7] = '{15'h0122, 1'b0, 2, 1, 16'hBEEF, 8'hEF};
    vecs[8] = '{15'h0300, 1'b0, 0, 3, 16'hC0DE, 8'hDE};
    vecs[9] = '{15'h0301, 1'b1, 0, 0, 16'h0000, 8'hC0};

    tick();
    tick();
    chk("rst_req", 32'(sdram_req), 32'(0));
    chk("rst_addr", 32'(sdram_addr), 32'(0));
    chk("rst_data", 32'(rom_data), 32'(0));
    rom_cs = 1'b1;
    #1;
    chk("rst_ok", 32'(rom_ok), 32'(0));
    rom_cs = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      access(vecs[i].addr, vecs[i].hit, vecs[i].ackd, vecs[i].dstd, vecs[i].data, vecs[i].expb);

    rom_cs = 1'b0;
    tick();
    chk("hold_ok", 32'(rom_ok), 32'(0));
    chk("hold_data", 32'(rom_data), 32'(8'hC0));

    // address change while the fetch is in flight
    rom_cs = 1'b1;
    rom_addr = 15'h0200;
    tick();
    chk("chg_req", 32'(sdram_req), 32'(1));
    chk("chg_addr", 32'(sdram_addr), 32'(14'h0100));
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    rom_addr = 15'h0300;
    #1;
    chk("chg_ok_wait", 32'(rom_ok), 32'(0));
    repeat (2) begin
      tick();
      chk("chg_ok_wait", 32'(rom_ok), 32'(0));
      chk("chg_req_wait", 32'(sdram_req), 32'(0));
    end
    sdram_dst = 1'b1;
    sdram_data = 16'h1122;
    tick();
    sdram_dst = 1'b0;
    chk("chg_ok_fill", 32'(rom_ok), 32'(0));
    rom_addr = 15'h0201;
    tick();
    chk("chg_tag_hit", 32'(rom_ok), 32'(1));
    chk("chg_tag_data", 32'(rom_data), 32'(8'h11));
    rom_addr = 15'h0300;
    #1;
    chk("chg_stale_ok", 32'(rom_ok), 32'(0));
    tick();
    chk("chg_req2", 32'(sdram_req), 32'(1));
    chk("chg_addr2", 32'(sdram_addr), 32'(14'h0180));
    chk("chg_stale_ok2", 32'(rom_ok), 32'(0));
    serve(0, 0, 16'h3344, 8'h44, 14'h0180);

    // flush during the data wait, then held high across the fill
    rom_cs = 1'b0;
    tick();
    rom_cs = 1'b1;
    rom_addr = 15'h0040;
    tick();
    chk("fl_req", 32'(sdram_req), 32'(1));
    chk("fl_addr", 32'(sdram_addr), 32'(14'h0020));
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_ok", 32'(rom_ok), 32'(0));
    sdram_dst = 1'b1;
    sdram_data = 16'hAAAA;
    flush = 1'b1;
    tick();
    sdram_dst = 1'b0;
    chk("fl_req_fill", 32'(sdram_req), 32'(0));
    chk("fl_ok_fill", 32'(rom_ok), 32'(0));
    tick();
    chk("fl_no_req", 32'(sdram_req), 32'(0));
    chk("fl_no_ok", 32'(rom_ok), 32'(0));
    flush = 1'b0;
    tick();
    chk("fl_refetch", 32'(sdram_req), 32'(1));
    chk("fl_refetch_addr", 32'(sdram_addr), 32'(14'h0020));
    serve(1, 1, 16'h55AA, 8'hAA, 14'h0020);

    // flush in IDLE with a valid line
    rom_addr = 15'h0041;
    tick();
    chk("fli_hit", 32'(rom_ok), 32'(1));
    chk("fli_data", 32'(rom_data), 32'(8'h55));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fli_ok", 32'(rom_ok), 32'(0));
    chk("fli_no_req", 32'(sdram_req), 32'(0));
    tick();
    chk("fli_req", 32'(sdram_req), 32'(1));
    chk("fli_addr", 32'(sdram_addr), 32'(14'h0020));
    serve(0, 2, 16'h55AA, 8'h55, 14'h0020);

    // reset in the middle of a request; a late dst must be ignored
    rom_cs = 1'b0;
    tick();
    rom_cs = 1'b1;
    rom_addr = 15'h0500;
    tick();
    chk("rr_req", 32'(sdram_req), 32'(1));
    rst = 1'b1;
    tick();
    chk("rr_req_drop", 32'(sdram_req), 32'(0));
    chk("rr_ok", 32'(rom_ok), 32'(0));
    chk("rr_addr", 32'(sdram_addr), 32'(0));
    chk("rr_data", 32'(rom_data), 32'(0));
    rst = 1'b0;
    rom_cs = 1'b0;
    sdram_dst = 1'b1;
    sdram_data = 16'h9999;
    tick();
    sdram_dst = 1'b0;
    access(15'h0000, 1'b0, 1, 1, 16'h0F0F, 8'h0F);

    // random accesses against the cache model
    rom_cs = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m_valid = 1'b0;
    m_tag = '0;
    for (int i = 0; i < 150; i++) begin
      logic [14:0] a;
      logic [15:0] d;
      bit          h;
      if ($urandom_range(0, 7) == 0) begin
        rom_cs = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_valid = 1'b0;
      end
      if (m_valid && $urandom_range(0, 1) == 1)
        a = {m_tag, 1'($urandom_range(0, 1))};
      else if ($urandom_range(0, 1) == 1)
        a = 15'($urandom_range(0, 15));
      else
        a = 15'($urandom);
      h = m_valid && (m_tag == a[14:1]);
      d = mem(a[14:1]);
      access(a, h, $urandom_range(0, 3), $urandom_range(0, 3), d,
             a[0] ? d[15:8] : d[7:0]);
      m_valid = 1'b1;
      m_tag = a[14:1];
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
